// File: rtl/cargador_serie_4bits.sv
// Serial-to-parallel loader: assembles 4 serial bits into D with a one-cycle EN strobe.
// Optional even parity bit after the data bits when CARGADOR_PARIDAD_EN is defined.
module cargador_serie_4bits #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    input  logic       sin_valid,
    output logic [3:0] D,
    output logic       EN,
    output logic       busy,
    output logic       err
);

`ifdef CARGADOR_PARIDAD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    // The abort fires on the idle cycle that would bring the counter to TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg;
    logic [3:0] shift_reg;
    logic [2:0] cnt_reg;
    logic [7:0] tmo_reg;
    logic [3:0] shift_next;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next = {shift_reg[2:0], sin};
        end else begin : g_lsb_first
            assign shift_next = {sin, shift_reg[3:1]};
        end
    endgenerate

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= 4'd0;
            cnt_reg   <= 3'd0;
            tmo_reg   <= 8'd0;
            D         <= 4'd0;
            EN        <= 1'b0;
            err       <= 1'b0;
        end else begin
            EN  <= 1'b0;
            err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (sin_valid) begin
                        shift_reg <= shift_next;
                        cnt_reg   <= 3'd1;
                        tmo_reg   <= 8'd0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sin_valid) begin
                        tmo_reg <= 8'd0;
                        if (cnt_reg == 3'd3) begin
                            cnt_reg <= 3'd0;
`ifdef CARGADOR_PARIDAD_EN
                            shift_reg <= shift_next;
                            state_reg <= PARITY;
`else
                            D         <= shift_next;
                            EN        <= 1'b1;
                            shift_reg <= 4'd0;
                            state_reg <= IDLE;
`endif
                        end else begin
                            shift_reg <= shift_next;
                            cnt_reg   <= cnt_reg + 3'd1;
                        end
                    end else if (tmo_reg == TMO_LAST) begin
                        err       <= 1'b1;
                        shift_reg <= 4'd0;
                        cnt_reg   <= 3'd0;
                        tmo_reg   <= 8'd0;
                        state_reg <= IDLE;
                    end else begin
                        tmo_reg <= tmo_reg + 8'd1;
                    end
                end
`ifdef CARGADOR_PARIDAD_EN
                PARITY: begin
                    if (sin_valid) begin
                        // Even parity: data bits plus parity bit must XOR to zero.
                        if (^{shift_reg, sin} == 1'b0) begin
                            D  <= shift_reg;
                            EN <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        shift_reg <= 4'd0;
                        tmo_reg   <= 8'd0;
                        state_reg <= IDLE;
                    end else if (tmo_reg == TMO_LAST) begin
                        err       <= 1'b1;
                        shift_reg <= 4'd0;
                        tmo_reg   <= 8'd0;
                        state_reg <= IDLE;
                    end else begin
                        tmo_reg <= tmo_reg + 8'd1;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
